// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, ALU op codes,
// FSM state encodings and datapath select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_FUNCT = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_IMMEX  = 4'd8,
    S_IMMWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_FAULT  = 4'd13
  } state_t;

  // States that hold mem_req and wait on mem_ready.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// Memory-wait timeout counter: cleared by load, counts enabled wait cycles and
// flags expiry on the wait cycle that brings the count to MEM_TIMEOUT.
module mc_mem_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [TO_W-1:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (load)
      count_next = '0;
    else if (enable)
      count_next = count_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer (FETCH/DECODE/EXEC/MEM/WB) with memory
// handshake timeout and sticky FAULT. Define MC_CTRL_PERF_EN for retire/stall counters.
module multicycle_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_source,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        ext_op,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic [3:0]  state_o,
  output logic        fault
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  state_t     state_reg, state_next;
  logic [5:0] op_reg;
  logic       mem_wait;
  logic       to_expired;

  // The beq condition is applied in the datapath through pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  assign mem_wait = is_mem_state(state_reg) && !mem_ready;

  mc_mem_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (!mem_wait),
    .enable  (mem_wait),
    .expired (to_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_FETCH;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE)
        op_reg <= opcode;
    end
  end

  // Outputs are gated by reset so an in-flight access drops without a clock edge.
  always_comb begin
    state_next    = state_reg;
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    alu_op        = ALU_ADD;
    ext_op        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = REGDST_RT;
    mem_to_reg    = M2R_ALUOUT;
    fault         = 1'b0;
    if (reset) begin
      case (state_reg)
        S_FETCH: begin
          mem_req   = 1'b1;
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            pc_source  = PCSRC_ALU;
            state_next = S_DECODE;
          end else if (to_expired) begin
            state_next = S_FAULT;
          end
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          ext_op    = 1'b1;
          case (opcode)
            OP_LW, OP_SW:    state_next = S_MEMADR;
            OP_RTYPE:        state_next = S_EXEC;
            OP_BEQ:          state_next = S_BRANCH;
            OP_ADDI, OP_ORI: state_next = S_IMMEX;
            OP_J:            state_next = S_JUMP;
            OP_JAL:          state_next = S_JAL;
            default:         state_next = S_FAULT;
          endcase
        end
        S_MEMADR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          ext_op     = 1'b1;
          state_next = (op_reg == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready)
            state_next = S_MEMWB;
          else if (to_expired)
            state_next = S_FAULT;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          reg_dst    = REGDST_RT;
          mem_to_reg = M2R_MDR;
          state_next = S_FETCH;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready)
            state_next = S_FETCH;
          else if (to_expired)
            state_next = S_FAULT;
        end
        S_EXEC: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_REGB;
          alu_op     = ALU_FUNCT;
          state_next = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = REGDST_RD;
          mem_to_reg = M2R_ALUOUT;
          state_next = S_FETCH;
        end
        S_IMMEX: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          ext_op     = (op_reg != OP_ORI);
          alu_op     = (op_reg == OP_ORI) ? ALU_OR : ALU_ADD;
          state_next = S_IMMWB;
        end
        S_IMMWB: begin
          reg_write  = 1'b1;
          reg_dst    = REGDST_RT;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRCB_REGB;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          state_next    = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          state_next = S_FETCH;
        end
        S_JAL: begin
          reg_write  = 1'b1;
          reg_dst    = REGDST_RA;
          mem_to_reg = M2R_PC;
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          state_next = S_FETCH;
        end
        S_FAULT: begin
          fault = 1'b1;
        end
        default: begin
          state_next = S_FAULT;
        end
      endcase
    end
  end

  assign state_o = state_reg;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] retired_reg, stall_reg;

  // FAULT never returns to FETCH, so any entry into FETCH is a retirement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_reg <= '0;
      stall_reg   <= '0;
    end else begin
      if ((state_next == S_FETCH) && (state_reg != S_FETCH))
        retired_reg <= retired_reg + 32'd1;
      if (mem_req && !mem_ready)
        stall_reg <= stall_reg + 32'd1;
    end
  end

  assign retired_cnt = retired_reg;
  assign stall_cnt   = stall_reg;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: the driver pushes the expected per-cycle
// control word for each instruction phase; a negedge monitor pops and compares.
module tb_multicycle_ctrl_fsm;
  import mips_ctrl_pkg::*;

  localparam int TO = 16;

  localparam logic [5:0] B_R    = 6'h00;
  localparam logic [5:0] B_J    = 6'h02;
  localparam logic [5:0] B_JAL  = 6'h03;
  localparam logic [5:0] B_BEQ  = 6'h04;
  localparam logic [5:0] B_ADDI = 6'h08;
  localparam logic [5:0] B_ORI  = 6'h0D;
  localparam logic [5:0] B_LW   = 6'h23;
  localparam logic [5:0] B_SW   = 6'h2B;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_source, alu_src_b, reg_dst, mem_to_reg;
  logic        alu_src_a, ext_op, reg_write, fault;
  logic [2:0]  alu_op;
  logic [3:0]  state_o;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] retired_cnt, stall_cnt;
  int unsigned exp_retired = 0;
  int unsigned exp_stall = 0;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO), .TO_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .ext_op(ext_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .state_o(state_o), .fault(fault)
`ifdef MC_CTRL_PERF_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_op, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       fault;
  } ctl_t;

  ctl_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Expected control word for one cycle, straight from the per-state output table.
  function automatic ctl_t model(state_t s, logic [5:0] op, logic rdy);
    ctl_t c = '0;
    c.st = s;
    case (s)
      S_FETCH:  begin c.mem_req = 1; c.mem_read = 1; c.alu_src_b = 2'b01;
                      if (rdy) begin c.ir_write = 1; c.pc_write = 1; end end
      S_DECODE: begin c.alu_src_b = 2'b11; c.ext_op = 1; end
      S_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.ext_op = 1; end
      S_MEMRD:  begin c.mem_req = 1; c.mem_read = 1; c.i_or_d = 1; end
      S_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
      S_MEMWR:  begin c.mem_req = 1; c.mem_write = 1; c.i_or_d = 1; end
      S_EXEC:   begin c.alu_src_a = 1; c.alu_op = 3'b100; end
      S_ALUWB:  begin c.reg_write = 1; c.reg_dst = 2'b01; end
      S_IMMEX:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10;
                      c.ext_op = (op == B_ADDI); c.alu_op = (op == B_ORI) ? 3'b010 : 3'b000; end
      S_IMMWB:  begin c.reg_write = 1; end
      S_BRANCH: begin c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      S_JUMP:   begin c.pc_write = 1; c.pc_source = 2'b10; end
      S_JAL:    begin c.reg_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
                      c.pc_write = 1; c.pc_source = 2'b10; end
      S_FAULT:  begin c.fault = 1; end
      default:  ;
    endcase
    return c;
  endfunction

  function automatic ctl_t rst_vec();
    ctl_t c = '0;
    c.st = S_FETCH;
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t a;
    a.st = state_o; a.mem_req = mem_req; a.mem_read = mem_read; a.mem_write = mem_write;
    a.i_or_d = i_or_d; a.ir_write = ir_write; a.pc_write = pc_write;
    a.pc_write_cond = pc_write_cond; a.pc_source = pc_source; a.alu_src_a = alu_src_a;
    a.alu_src_b = alu_src_b; a.alu_op = alu_op; a.ext_op = ext_op; a.reg_write = reg_write;
    a.reg_dst = reg_dst; a.mem_to_reg = mem_to_reg; a.fault = fault;
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: one comparison per expected cycle.
  always @(negedge clk) begin
    ctl_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = sample();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL ctl t=%0t st_got=%0d st_want=%0d got=%h want=%h", $time, a.st, e.st, a, e);
      end
    end
  end

  // One clock cycle of stimulus plus its expected outputs; entered and left at posedge+1.
  task automatic step(input state_t s, input logic [5:0] op, input logic [5:0] live, input logic rdy);
    mem_ready = rdy;
    opcode    = live;
    zero      = 1'($urandom_range(0, 1));
    exp_q.push_back(model(s, op, rdy));
`ifdef MC_CTRL_PERF_EN
    if ((s == S_FETCH || s == S_MEMRD || s == S_MEMWR) && !rdy) exp_stall++;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic mem_access(input state_t s, input logic [5:0] op, input int w, output bit faulted);
    faulted = (w >= TO);
    for (int i = 0; i < w && i < TO; i++) step(s, op, 6'($urandom), 1'b0);
    if (!faulted) step(s, op, 6'($urandom), 1'b1);
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, output bit faulted);
    mem_access(S_FETCH, op, wf, faulted);
    if (!faulted) begin
      step(S_DECODE, op, op, 1'($urandom_range(0, 1)));
      case (op)
        B_LW: begin
          step(S_MEMADR, op, 6'($urandom), 1'($urandom_range(0, 1)));
          mem_access(S_MEMRD, op, wm, faulted);
          if (!faulted) step(S_MEMWB, op, 6'($urandom), 1'($urandom_range(0, 1)));
        end
        B_SW: begin
          step(S_MEMADR, op, 6'($urandom), 1'($urandom_range(0, 1)));
          mem_access(S_MEMWR, op, wm, faulted);
        end
        B_R: begin
          step(S_EXEC, op, 6'($urandom), 1'($urandom_range(0, 1)));
          step(S_ALUWB, op, 6'($urandom), 1'($urandom_range(0, 1)));
        end
        B_ADDI, B_ORI: begin
          step(S_IMMEX, op, 6'($urandom), 1'($urandom_range(0, 1)));
          step(S_IMMWB, op, 6'($urandom), 1'($urandom_range(0, 1)));
        end
        B_BEQ: step(S_BRANCH, op, 6'($urandom), 1'($urandom_range(0, 1)));
        B_J:   step(S_JUMP, op, 6'($urandom), 1'($urandom_range(0, 1)));
        B_JAL: step(S_JAL, op, 6'($urandom), 1'($urandom_range(0, 1)));
        default: faulted = 1'b1;
      endcase
    end
`ifdef MC_CTRL_PERF_EN
    if (!faulted) exp_retired++;
`endif
    $display("instr op=%02h wf=%0d wm=%0d %s", op, wf, wm, faulted ? "-> fault" : "ok");
  endtask

  task automatic fault_hold(input int n);
    for (int i = 0; i < n; i++) step(S_FAULT, 6'd0, 6'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic check_perf();
`ifdef MC_CTRL_PERF_EN
    check("retired_cnt", retired_cnt, exp_retired);
    check("stall_cnt", stall_cnt, exp_stall);
`endif
  endtask

  // Reset asserted between edges; outputs must collapse without a clock.
  task automatic async_reset(input string name);
    #2;
    reset = 1'b0;
    #1;
    check(name, {6'd0, sample()}, {6'd0, rst_vec()});
    @(posedge clk);
    #1;
    reset = 1'b1;
`ifdef MC_CTRL_PERF_EN
    exp_retired = 0;
    exp_stall = 0;
`endif
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [5:0] legal [8];
    bit f;
    legal = '{B_R, B_J, B_JAL, B_BEQ, B_ADDI, B_ORI, B_LW, B_SW};

    mem_ready = 1'b1;
    #3;
    check("reset_ctl", {6'd0, sample()}, {6'd0, rst_vec()});
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Directed phase: one of each, plus wait-state and timeout-boundary cases.
    run_instr(B_LW, 0, 0, f);
    run_instr(B_R, 3, 0, f);
    run_instr(B_BEQ, 0, 0, f);
    run_instr(B_JAL, 0, 0, f);
    run_instr(B_J, 1, 0, f);
    run_instr(B_ADDI, 0, 0, f);
    run_instr(B_ORI, 2, 0, f);
    run_instr(B_SW, 0, 2, f);
    run_instr(B_SW, 0, TO - 1, f);
    run_instr(B_LW, 1, TO - 1, f);
    run_instr(B_BEQ, TO - 1, 0, f);
    check_perf();

    for (int n = 0; n < 60; n++) begin
      run_instr(legal[$urandom_range(0, 7)], rand_wait(), rand_wait(), f);
    end
    check_perf();

    // Reset while a fetch is waiting on memory.
    step(S_FETCH, 6'd0, 6'($urandom), 1'b0);
    step(S_FETCH, 6'd0, 6'($urandom), 1'b0);
    check_perf();
    async_reset("rst_mid_access");

    run_instr(6'b111111, 0, 0, f);
    check("illegal_faulted", 32'(f), 32'd1);
    fault_hold(5);
    check_perf();
    async_reset("rst_from_fault_illegal");

    run_instr(B_ADDI, 0, 0, f);
    run_instr(B_SW, 0, TO, f);
    fault_hold(4);
    check_perf();
    async_reset("rst_from_fault_sw_to");

    run_instr(B_R, TO, 0, f);
    fault_hold(3);
    async_reset("rst_from_fault_fetch_to");

    run_instr(B_LW, 0, 0, f);
    run_instr(B_JAL, 0, 0, f);
    check_perf();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
